datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: Datapath

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 clr  in  1  reset, synchronous, active-high.
REQ-003 R0in..R15in, HIin, LOin, PCin, IRin, MARin, MDRin, Yin, Zin  in  1 each  register load enables. Unconnected enables read as 0.
REQ-004 R0out..R15out, HIout, LOout, PCout, MDRout, Zhighout, Zlowout  in  1 each  bus-drive selects.
REQ-005 Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-006 OpCode  in  5  ALU operation select.
REQ-007 Mdatain  in  32  memory read data.
REQ-008 BusMuxOut  out  32  internal bus value, exported for observation.
REQ-009 MARout_q  out  32  MAR contents, exported for memory address.

Function
REQ-010 Registers: R0-R15, HI, LO, PC, IR, MAR, MDR, Y, each 32 bits; Z is 64 bits (Zhigh = [63:32], Zlow = [31:0]).
REQ-011 Bus is combinational.
- Fixed priority: R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout; the first asserted select drives.
- No select asserted: bus = 0.
REQ-012 Register load: enable high at a rising edge captures the bus value; otherwise the register holds.
REQ-013 MDR loads on MDRin from Mdatain when Read = 1, else from the bus.
REQ-014 IR and MAR load from the bus; they have no bus-drive path.
REQ-015 ALU is combinational, with A = Y and B = bus. Z captures the ALU result on Zin. 32-bit results zero-extend into Z[63:32].
REQ-016 OpCode map:
- 0 ADD (A+B); 1 SUB (A-B); 2 AND; 3 OR.
- 4 SHR logical; 5 SHRA arithmetic; 6 SHL; 7 ROR; 8 ROL. Shift amount = B[4:0].
- 9 MUL: signed 32x32 giving 64 bits.
- 10 DIV: signed; Zlow = quotient, Zhigh = remainder; B = 0 gives Z = 0.
- 11 NEG (-B); 12 INC (B+1); 13 NOT (~B).
- 14-31: Z result = 0.
REQ-017 ADD, SUB, INC and NEG wrap modulo 2^32 with no flags. INC of 0xFFFFFFFF gives Zlow = 0.
REQ-018 Simultaneous load and drive of the same register in one cycle: the bus carries the old value, and the register captures it (no change).
REQ-019 Multiple load enables in one cycle: every enabled register captures the same bus value.
REQ-020 Latency: a register loaded at edge N is visible on the bus after edge N. A full ALU operation (Y load, then Z load, then Z drive) takes 3 edges.

Reset
REQ-021 clr = 1 at a rising edge clears every register (R0-R15, HI, LO, PC, IR, MAR, MDR, Y, Z) to 0. The bus then reads 0 when no register is selected.
REQ-022 clr overrides all load enables in the same cycle.
REQ-023 clr asserted mid-sequence discards any partially completed operation; no state is retained.

Verification
REQ-024 Register load via MDR:
- Mdatain = 0, Read + MDRin, then MDRout + R0in gives R0 = 0x00000000.
- Mdatain = 57, same sequence with R1in gives R1 = 0x00000039.
REQ-025 PC increment:
- PC = 0; PCout + MARin + Zin with OpCode 12 gives MAR = 0 and Zlow = 1.
- Then Zlowout + PCin gives PC = 1.
REQ-026 Instruction fetch: Mdatain = 0x28918000 with Read + MDRin, then MDRout + IRin gives IR = 0x28918000.
REQ-027 NOT: R1 = 57; R1out + Zin with OpCode 13, then Zlowout + R0in gives R0 = 0xFFFFFFC6.
REQ-028 MUL and DIV:
- Y = 0xFFFFFFFE (-2), B = 3, OpCode 9 gives Zhigh = 0xFFFFFFFF, Zlow = 0xFFFFFFFA.
- Y = 7, B = 2, OpCode 10 gives Zlow = 3, Zhigh = 1.
- B = 0, OpCode 10 gives Z = 0.
REQ-029 Reset: load R5 = 0x12345678, then assert clr with R5in and MDRout both high. Required: R5 = 0 and all registers = 0 after that edge.

Source files
------------

// File: rtl/datapath.sv
// Bus-based CPU datapath: 16 GPRs plus HI/LO/PC/IR/MAR/MDR/Y, a 64-bit Z
// result register, a fixed-priority shared bus and a combinational ALU.
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        Read,
    input  logic [4:0]  OpCode,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] MARout_q
);

    logic [15:0] r_in;
    logic [15:0] r_out;
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    logic [31:0] gpr_q [16];
    logic [31:0] gpr_d [16];
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [31:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [31:0] bus;
    logic [63:0] alu_res;

    // Lowest priority assigned first so the highest-priority select wins.
    always_comb begin
        bus = 32'd0;
        if (MDRout)   bus = mdr_q;
        if (PCout)    bus = pc_q;
        if (Zlowout)  bus = z_q[31:0];
        if (Zhighout) bus = z_q[63:32];
        if (LOout)    bus = lo_q;
        if (HIout)    bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus = gpr_q[i];
        end
    end
    assign BusMuxOut = bus;
    assign MARout_q  = mar_q;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_gpr
            assign gpr_d[gi] = r_in[gi] ? bus : gpr_q[gi];
        end
    endgenerate

    always_comb begin
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        pc_d  = PCin  ? bus : pc_q;
        ir_d  = IRin  ? bus : ir_q;
        mar_d = MARin ? bus : mar_q;
        y_d   = Yin   ? bus : y_q;
        mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        z_d   = Zin   ? alu_res : z_q;
    end

    // ALU: A is Y, B is the bus
    logic [31:0]        alu_a, alu_b, shra_v, quo_v, rem_v;
    logic signed [31:0] a_s, b_div;
    logic [4:0]         sh;
    logic [63:0]        aa, ror_t, rol_t, prod_v;
    assign alu_a  = y_q;
    assign alu_b  = bus;
    assign sh     = alu_b[4:0];
    assign a_s    = alu_a;
    assign shra_v = a_s >>> sh;
    assign aa     = {alu_a, alu_a};
    assign ror_t  = aa >> sh;
    assign rol_t  = aa << sh;
    assign prod_v = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
    // Divisor forced nonzero so the divider never sees 0; the result is masked below.
    assign b_div  = (alu_b == 32'd0) ? 32'sd1 : alu_b;
    assign quo_v  = a_s / b_div;
    assign rem_v  = a_s % b_div;

    always_comb begin
        alu_res = 64'd0;
        case (OpCode)
            5'd0:  alu_res = {32'd0, alu_a + alu_b};
            5'd1:  alu_res = {32'd0, alu_a - alu_b};
            5'd2:  alu_res = {32'd0, alu_a & alu_b};
            5'd3:  alu_res = {32'd0, alu_a | alu_b};
            5'd4:  alu_res = {32'd0, alu_a >> sh};
            5'd5:  alu_res = {32'd0, shra_v};
            5'd6:  alu_res = {32'd0, alu_a << sh};
            5'd7:  alu_res = {32'd0, ror_t[31:0]};
            5'd8:  alu_res = {32'd0, rol_t[63:32]};
            5'd9:  alu_res = prod_v;
            5'd10: alu_res = (alu_b == 32'd0) ? 64'd0 : {rem_v, quo_v};
            5'd11: alu_res = {32'd0, 32'd0 - alu_b};
            5'd12: alu_res = {32'd0, alu_b + 32'd1};
            5'd13: alu_res = {32'd0, ~alu_b};
            default: alu_res = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            pc_q  <= 32'd0;
            ir_q  <= 32'd0;
            mar_q <= 32'd0;
            mdr_q <= 32'd0;
            y_q   <= 32'd0;
            z_q   <= 64'd0;
        end else begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: expected values are queued when stimulus is
// applied and popped when the corresponding output is observed.
module tb_datapath;

    logic        clk;
    logic        clr;
    logic [15:0] r_in, r_out;
    logic        hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
    logic        hi_out, lo_out, pc_out, mdr_out, zh_out, zl_out, rd;
    logic [4:0]  op;
    logic [31:0] mdat;
    logic [31:0] bus_out, mar_out;

    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam int SRC_HI = 16, SRC_LO = 17, SRC_ZH = 18, SRC_ZL = 19;
    localparam int SRC_PC = 20, SRC_MDR = 21, SRC_NONE = -1;
    localparam int DST_Y = 22, DST_IR = 23, DST_MAR = 24;

    datapath dut (
        .clk(clk), .clr(clr),
        .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
        .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
        .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .HIin(hi_in), .LOin(lo_in), .PCin(pc_in), .IRin(ir_in),
        .MARin(mar_in), .MDRin(mdr_in), .Yin(y_in), .Zin(z_in),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .HIout(hi_out), .LOout(lo_out), .PCout(pc_out), .MDRout(mdr_out),
        .Zhighout(zh_out), .Zlowout(zl_out),
        .Read(rd), .OpCode(op), .Mdatain(mdat),
        .BusMuxOut(bus_out), .MARout_q(mar_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_ctrl();
        clr = 1'b0; r_in = '0; r_out = '0;
        hi_in = 0; lo_in = 0; pc_in = 0; ir_in = 0; mar_in = 0; mdr_in = 0; y_in = 0; z_in = 0;
        hi_out = 0; lo_out = 0; pc_out = 0; mdr_out = 0; zh_out = 0; zl_out = 0; rd = 0;
        op = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic set_src(int src);
        if (src >= 0 && src < 16) r_out[src] = 1'b1;
        else if (src == SRC_HI)  hi_out  = 1'b1;
        else if (src == SRC_LO)  lo_out  = 1'b1;
        else if (src == SRC_ZH)  zh_out  = 1'b1;
        else if (src == SRC_ZL)  zl_out  = 1'b1;
        else if (src == SRC_PC)  pc_out  = 1'b1;
        else if (src == SRC_MDR) mdr_out = 1'b1;
    endtask

    task automatic set_dst(int dst);
        if (dst >= 0 && dst < 16) r_in[dst] = 1'b1;
        else if (dst == SRC_HI)  hi_in  = 1'b1;
        else if (dst == SRC_LO)  lo_in  = 1'b1;
        else if (dst == SRC_PC)  pc_in  = 1'b1;
        else if (dst == DST_Y)   y_in   = 1'b1;
        else if (dst == DST_IR)  ir_in  = 1'b1;
        else if (dst == DST_MAR) mar_in = 1'b1;
    endtask

    task automatic check(string tag, logic [31:0] observed);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, observed);
        end else begin
            e = exp_q.pop_front();
            assert (observed === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, observed, e);
            end
        end
    endtask

    // Drive one (or no) bus source and compare the bus against the queued value.
    task automatic read_bus(string tag, int src, logic [31:0] expv);
        exp_q.push_back(expv);
        set_src(src);
        #1;
        check(tag, bus_out);
        clear_ctrl();
    endtask

    task automatic load(int dst, logic [31:0] val);
        mdat = val; rd = 1'b1; mdr_in = 1'b1;
        tick();
        mdr_out = 1'b1;
        set_dst(dst);
        tick();
    endtask

    task automatic alu_case(logic [4:0] opc, logic [31:0] a, logic [31:0] b,
                            logic [31:0] hi, logic [31:0] lo);
        load(DST_Y, a);
        load(2, b);
        r_out[2] = 1'b1; z_in = 1'b1; op = opc;
        tick();
        read_bus($sformatf("op%0d_zhigh", opc), SRC_ZH, hi);
        read_bus($sformatf("op%0d_zlow", opc), SRC_ZL, lo);
    endtask

    initial begin
        clear_ctrl();
        mdat = '0;
        clr = 1'b1;
        tick();

        read_bus("rst_idle_bus", SRC_NONE, 32'd0);
        read_bus("rst_r5", 5, 32'd0);
        exp_q.push_back(32'd0); check("rst_mar", mar_out);

        load(0, 32'd0);
        read_bus("mdr_r0", 0, 32'h0000_0000);
        load(1, 32'd57);
        read_bus("mdr_r1", 1, 32'h0000_0039);

        pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; op = 5'd12;
        tick();
        exp_q.push_back(32'd0); check("pcinc_mar", mar_out);
        read_bus("pcinc_zlow", SRC_ZL, 32'd1);
        zl_out = 1'b1; pc_in = 1'b1;
        tick();
        read_bus("pcinc_pc", SRC_PC, 32'd1);

        load(DST_IR, 32'h2891_8000);
        exp_q.push_back(32'h2891_8000); check("fetch_ir", dut.ir_q);

        r_out[1] = 1'b1; z_in = 1'b1; op = 5'd13;
        tick();
        zl_out = 1'b1; r_in[0] = 1'b1;
        tick();
        read_bus("not_r0", 0, 32'hFFFF_FFC6);

        alu_case(5'd9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
        alu_case(5'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1);
        alu_case(5'd9,  32'd7,         32'd6,         32'h0,         32'd42);
        alu_case(5'd10, 32'd7,         32'd2,         32'd1,         32'd3);
        alu_case(5'd10, 32'd7,         32'd0,         32'd0,         32'd0);
        alu_case(5'd10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        alu_case(5'd0,  32'hFFFF_FFFF, 32'd2,         32'h0,         32'h1);
        alu_case(5'd1,  32'd3,         32'd5,         32'h0,         32'hFFFF_FFFE);
        alu_case(5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'hF000_F000);
        alu_case(5'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0,         32'hFFFF_F0F0);
        alu_case(5'd4,  32'h8000_0000, 32'd4,         32'h0,         32'h0800_0000);
        alu_case(5'd5,  32'h8000_0000, 32'd4,         32'h0,         32'hF800_0000);
        alu_case(5'd6,  32'h0000_0001, 32'd31,        32'h0,         32'h8000_0000);
        alu_case(5'd7,  32'h0000_0001, 32'd1,         32'h0,         32'h8000_0000);
        alu_case(5'd7,  32'h1234_5678, 32'd32,        32'h0,         32'h1234_5678);
        alu_case(5'd8,  32'h8000_0000, 32'd1,         32'h0,         32'h0000_0001);
        alu_case(5'd11, 32'd0,         32'd5,         32'h0,         32'hFFFF_FFFB);
        alu_case(5'd12, 32'd0,         32'hFFFF_FFFF, 32'h0,         32'h0);
        alu_case(5'd13, 32'd0,         32'd0,         32'h0,         32'hFFFF_FFFF);
        alu_case(5'd20, 32'd5,         32'd5,         32'h0,         32'h0);

        load(3, 32'hAAAA_5555);
        r_out[3] = 1'b1; r_in[3] = 1'b1;
        tick();
        read_bus("self_load_r3", 3, 32'hAAAA_5555);

        mdat = 32'h0BAD_F00D; rd = 1'b1; mdr_in = 1'b1;
        tick();
        mdr_out = 1'b1; r_in[4] = 1'b1; r_in[6] = 1'b1;
        tick();
        read_bus("multi_r4", 4, 32'h0BAD_F00D);
        read_bus("multi_r6", 6, 32'h0BAD_F00D);

        load(SRC_HI, 32'hDEAD_BEEF);
        load(SRC_LO, 32'h0000_1111);
        r_out[3] = 1'b1; r_out[4] = 1'b1;
        read_bus("prio_r3_r4", SRC_NONE, 32'hAAAA_5555);
        hi_out = 1'b1;
        read_bus("prio_hi_lo", SRC_LO, 32'hDEAD_BEEF);
        pc_out = 1'b1;
        read_bus("prio_pc_mdr", SRC_MDR, 32'h0000_0001);

        load(5, 32'h1234_5678);
        read_bus("pre_clr_r5", 5, 32'h1234_5678);
        clr = 1'b1; r_in[5] = 1'b1; mdr_out = 1'b1;
        tick();
        read_bus("clr_r5", 5, 32'd0);
        read_bus("clr_r1", 1, 32'd0);
        read_bus("clr_hi", SRC_HI, 32'd0);
        read_bus("clr_pc", SRC_PC, 32'd0);
        read_bus("clr_mdr", SRC_MDR, 32'd0);
        read_bus("clr_zhigh", SRC_ZH, 32'd0);
        read_bus("clr_zlow", SRC_ZL, 32'd0);
        read_bus("clr_idle_bus", SRC_NONE, 32'd0);
        exp_q.push_back(32'd0); check("clr_y", dut.y_q);
        exp_q.push_back(32'd0); check("clr_ir", dut.ir_q);
        exp_q.push_back(32'd0); check("clr_mar", mar_out);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
